regfile_scoreboard: RTL and testbench

// - Parametrised successor register file for the pipelined RISC-V core: 2 operand read ports + 1 debug read port, 1 write-back port.
// - Adds write-to-read bypass and a per-register pending-write scoreboard (up/down counters) so decode can detect RAW hazards and stall.
// - Sits between decode/issue (reads, issue of rd) and write-back stage (wb writes).

---
 rtl/regfile_scoreboard_pkg.sv | 20 ++
 rtl/regfile_scoreboard_if.sv | 42 ++++
 rtl/rf_pend_counter.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_scoreboard.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Package    : rf_pkg
// Description: Default sizing constants and address-width helper shared by
//              the register file, its interface and the pending counters.
// Revision   : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_PEND_W   = 2;

    // Address width for a register count; at least one bit even for 2 regs.
    function automatic int addr_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Interface  : regfile_scoreboard_if
// Description: Decode/issue and write-back signals of the register file.
//              master = pipeline side, slave = register file.
// Revision   : 1.0 - initial release
// ============================================================================
interface regfile_scoreboard_if #(
    parameter int WIDTH  = rf_pkg::DEF_WIDTH,
    parameter int ADDR_W = rf_pkg::addr_w(rf_pkg::DEF_NUM_REGS)
);
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [WIDTH-1:0]  rs1_data;
    logic [WIDTH-1:0]  rs2_data;
    logic [WIDTH-1:0]  dbg_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              wb_err;

    modport master (
        output rs1_addr, rs2_addr, dbg_addr, issue_valid, issue_rd,
               wb_valid, wb_addr, wb_data,
        input  rs1_data, rs2_data, dbg_data, rs1_busy, rs2_busy,
               issue_ready, wb_err
    );

    modport slave (
        input  rs1_addr, rs2_addr, dbg_addr, issue_valid, issue_rd,
               wb_valid, wb_addr, wb_data,
        output rs1_data, rs2_data, dbg_data, rs1_busy, rs2_busy,
               issue_ready, wb_err
    );
endinterface
`default_nettype wire

// File: rtl/rf_pend_counter.sv
`default_nettype none
// ============================================================================
// Module     : rf_pend_counter
// Description: Pending-write counter for one register. Increments on issue,
//              decrements on write-back, holds when both occur together.
//              Never wraps: increment at max and decrement at zero are held.
// Revision   : 1.0 - initial release
// ============================================================================
module rf_pend_counter #(
    parameter int PEND_W = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic inc_i,
    input  wire logic dec_i,
    output logic      is_zero_o,
    output logic      is_max_o,
    output logic      is_one_o
);
    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    assign is_zero_o = (cnt_q == '0);
    assign is_max_o  = (cnt_q == '1);
    assign is_one_o  = (cnt_q == PEND_W'(1));

    // Next count: simultaneous inc/dec cancel; guard both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !is_max_o) begin
            cnt_d = cnt_q + PEND_W'(1);
        end else if (dec_i && !inc_i && !is_zero_o) begin
            cnt_d = cnt_q - PEND_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module     : regfile_scoreboard
// Description: Register file with two bypassed operand read ports, one
//              unbypassed debug read port, one write-back port, and a
//              per-register pending-write scoreboard for RAW hazard stalls.
// Revision   : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int PEND_W   = DEF_PEND_W
) (
    input  wire logic          clk,
    input  wire logic          reset,
    regfile_scoreboard_if.slave bus
);
    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [WIDTH-1:0]    rf_w [NUM_REGS];
    logic [NUM_REGS-1:0] zero_w;
    logic [NUM_REGS-1:0] one_w;
    logic [NUM_REGS-1:0] max_w;
    logic                wb_en_w;
    logic                wb_hit_issue_w;
    logic                issue_acc_w;
    logic                rs1_wb_hit_w;
    logic                rs2_wb_hit_w;
    logic                err_set_w;
    logic                err_q;

    // Register 0 reads as zero and never has pending writes.
    assign rf_w[0]   = '0;
    assign zero_w[0] = 1'b1;
    assign one_w[0]  = 1'b0;
    assign max_w[0]  = 1'b0;

    assign wb_en_w        = bus.wb_valid && (bus.wb_addr != '0);
    assign wb_hit_issue_w = bus.wb_valid && (bus.wb_addr == bus.issue_rd);

    // A full counter can still accept an issue when a write-back drains it
    // in the same cycle.
    assign bus.issue_ready = !((bus.issue_rd != '0) && max_w[bus.issue_rd]
                               && !wb_hit_issue_w);
    assign issue_acc_w     = bus.issue_valid && bus.issue_ready
                             && (bus.issue_rd != '0);

    // Storage and pending counter for each writable register.
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [WIDTH-1:0] data_q;
        logic             inc_w;
        logic             dec_w;

        assign inc_w = issue_acc_w && (bus.issue_rd == ADDR_W'(r));
        assign dec_w = bus.wb_valid && (bus.wb_addr == ADDR_W'(r));

        // Write-back data capture.
        always_ff @(posedge clk) begin
            if (reset)                                       data_q <= '0;
            else if (wb_en_w && (bus.wb_addr == ADDR_W'(r))) data_q <= bus.wb_data;
        end

        rf_pend_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc_i     (inc_w),
            .dec_i     (dec_w),
            .is_zero_o (zero_w[r]),
            .is_max_o  (max_w[r]),
            .is_one_o  (one_w[r])
        );

        assign rf_w[r] = data_q;
    end

    // Operand reads forward same-cycle write-back data; debug read does not.
    assign rs1_wb_hit_w = wb_en_w && (bus.wb_addr == bus.rs1_addr);
    assign rs2_wb_hit_w = wb_en_w && (bus.wb_addr == bus.rs2_addr);

    assign bus.rs1_data = rs1_wb_hit_w ? bus.wb_data : rf_w[bus.rs1_addr];
    assign bus.rs2_data = rs2_wb_hit_w ? bus.wb_data : rf_w[bus.rs2_addr];
    assign bus.dbg_data = rf_w[bus.dbg_addr];

    // Busy unless the last outstanding write is being written back right now.
    assign bus.rs1_busy = (!zero_w[bus.rs1_addr] && !one_w[bus.rs1_addr])
                          || (one_w[bus.rs1_addr] && !rs1_wb_hit_w);
    assign bus.rs2_busy = (!zero_w[bus.rs2_addr] && !one_w[bus.rs2_addr])
                          || (one_w[bus.rs2_addr] && !rs2_wb_hit_w);

    // Unexpected write-back: nothing pending and no matching issue this cycle.
    assign err_set_w = wb_en_w && zero_w[bus.wb_addr]
                       && !(issue_acc_w && (bus.issue_rd == bus.wb_addr));

    // Sticky write-back error flag.
    always_ff @(posedge clk) begin
        if (reset)          err_q <= 1'b0;
        else if (err_set_w) err_q <= 1'b1;
    end

    assign bus.wb_err = err_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module     : tb_regfile_scoreboard
// Description: Self-checking bench: directed vector table followed by
//              randomized traffic compared against a behavioural model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
    localparam int NR   = 32;
    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    regfile_scoreboard #(.WIDTH(32), .NUM_REGS(NR), .PEND_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rst;
        bit          iv;
        logic [4:0]  ird;
        bit          wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1, a2, ad;
        bit          chk;
        logic [31:0] e1, e2, ed;
        bit          eb1, eb2, erdy, eerr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model state
    logic [31:0] m_regs [NR];
    int          m_cnt  [NR];
    bit          m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(bit rst, bit iv, logic [4:0] ird, bit wv, logic [4:0] wa,
                                logic [31:0] wd, logic [4:0] a1, logic [4:0] a2, logic [4:0] ad,
                                bit c, logic [31:0] e1, logic [31:0] e2, logic [31:0] ed,
                                bit eb1, bit eb2, bit erdy, bit eerr);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ird = ird; v.wv = wv; v.wa = wa; v.wd = wd;
        v.a1 = a1; v.a2 = a2; v.ad = ad; v.chk = c;
        v.e1 = e1; v.e2 = e2; v.ed = ed; v.eb1 = eb1; v.eb2 = eb2; v.erdy = erdy; v.eerr = eerr;
        vecs.push_back(v);
    endfunction

    // Model views of the combinational outputs for the currently driven inputs
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.wb_valid && bus.wb_addr == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        bit drain = bus.wb_valid && (bus.wb_addr == a);
        if (a == 0) return 1'b0;
        return (m_cnt[a] > 1) || (m_cnt[a] == 1 && !drain);
    endfunction

    function automatic bit m_ready();
        int r = int'(bus.issue_rd);
        if (r == 0) return 1'b1;
        return !(m_cnt[r] == MAXC && bus.wb_valid && bus.wb_addr == bus.issue_rd) ?
               (m_cnt[r] != MAXC) || (bus.wb_valid && bus.wb_addr == bus.issue_rd) : 1'b1;
    endfunction

    // Advance model by one clock edge with the currently driven inputs
    function automatic void m_step();
        int  rd = int'(bus.issue_rd);
        int  wa = int'(bus.wb_addr);
        bit  acc;
        if (reset) begin
            for (int i = 0; i < NR; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
            m_err = 0;
            return;
        end
        acc = bus.issue_valid && m_ready() && rd != 0;
        if (bus.wb_valid && wa != 0) m_regs[wa] = bus.wb_data;
        if (acc && bus.wb_valid && wa == rd) return;
        if (acc) m_cnt[rd] = m_cnt[rd] + 1;
        if (bus.wb_valid && wa != 0) begin
            if (m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
            else               m_err = 1;
        end
    endfunction

    task automatic drive(input vec_t v);
        reset           = v.rst;
        bus.issue_valid = v.iv;
        bus.issue_rd    = v.ird;
        bus.wb_valid    = v.wv;
        bus.wb_addr     = v.wa;
        bus.wb_data     = v.wd;
        bus.rs1_addr    = v.a1;
        bus.rs2_addr    = v.a2;
        bus.dbg_addr    = v.ad;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rs1_data"}, bus.rs1_data, m_read(bus.rs1_addr));
        chk({tag, "_rs2_data"}, bus.rs2_data, m_read(bus.rs2_addr));
        chk({tag, "_dbg_data"}, bus.dbg_data, (bus.dbg_addr == 0) ? 32'h0 : m_regs[bus.dbg_addr]);
        chk({tag, "_rs1_busy"}, {31'h0, bus.rs1_busy}, {31'h0, m_busy(bus.rs1_addr)});
        chk({tag, "_rs2_busy"}, {31'h0, bus.rs2_busy}, {31'h0, m_busy(bus.rs2_addr)});
        chk({tag, "_issue_ready"}, {31'h0, bus.issue_ready}, {31'h0, m_ready()});
        chk({tag, "_wb_err"}, {31'h0, bus.wb_err}, {31'h0, m_err});
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < NR; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
        m_err = 0;

        // Directed table:       rst iv ird wv wa wd            a1 a2 ad chk e1/e2/ed                          b1 b2 rdy err
        add(1,0,0, 0,0,32'h0,        0,0,0,  0, 0,0,0,                               0,0,1,0);
        add(0,0,0, 0,0,32'h0,        0,5,31, 1, 0,0,0,                               0,0,1,0);
        add(0,0,0, 1,5,32'hDEADBEEF, 5,0,5,  1, 32'hDEADBEEF,0,0,                    0,0,1,0);
        add(0,0,0, 0,0,32'h0,        5,0,5,  1, 32'hDEADBEEF,0,32'hDEADBEEF,         0,0,1,1);
        add(1,0,0, 0,0,32'h0,        0,0,0,  0, 0,0,0,                               0,0,1,0);
        add(0,1,7, 0,0,32'h0,        7,0,0,  1, 0,0,0,                               0,0,1,0);
        add(0,1,7, 0,0,32'h0,        7,0,0,  1, 0,0,0,                               1,0,1,0);
        add(0,1,7, 0,0,32'h0,        7,0,0,  1, 0,0,0,                               1,0,1,0);
        add(0,1,7, 0,0,32'h0,        7,0,0,  1, 0,0,0,                               1,0,0,0);
        add(0,0,7, 1,7,32'hAA,       7,0,0,  1, 32'hAA,0,0,                          1,0,1,0);
        add(0,0,7, 0,0,32'h0,        7,7,0,  1, 32'hAA,32'hAA,0,                     1,1,1,0);
        add(0,0,0, 1,7,32'h55,       7,0,0,  1, 32'h55,0,0,                          1,0,1,0);
        add(0,0,0, 1,7,32'h12,       0,7,0,  1, 0,32'h12,0,                          0,0,1,0);
        add(0,1,7, 0,0,32'h0,        7,0,0,  1, 32'h12,0,0,                          0,0,1,0);
        add(0,1,7, 1,7,32'h34,       7,0,0,  1, 32'h34,0,0,                          0,0,1,0);
        add(0,0,0, 0,0,32'h0,        7,0,0,  1, 32'h34,0,0,                          1,0,1,0);
        add(0,0,0, 1,7,32'h9,        7,0,0,  1, 32'h9,0,0,                           0,0,1,0);
        add(0,0,0, 0,0,32'h0,        7,0,0,  1, 32'h9,0,0,                           0,0,1,0);
        add(0,0,0, 1,3,32'h77,       3,0,3,  1, 32'h77,0,0,                          0,0,1,0);
        add(0,0,0, 1,0,32'hFFFF,     0,0,3,  1, 0,0,32'h77,                          0,0,1,1);
        add(0,0,0, 0,0,32'h0,        0,3,0,  1, 0,32'h77,0,                          0,0,1,1);
        add(0,1,7, 0,0,32'h0,        7,0,0,  1, 32'h9,0,0,                           0,0,1,1);
        add(0,1,9, 0,0,32'h0,        7,9,0,  1, 32'h9,0,0,                           1,0,1,1);
        add(1,1,7, 0,0,32'h0,        0,0,0,  0, 0,0,0,                               0,0,1,0);
        add(0,0,7, 0,0,32'h0,        7,9,3,  1, 0,0,0,                               0,0,1,0);
        add(0,1,0, 0,0,32'h0,        0,0,0,  1, 0,0,0,                               0,0,1,0);
        add(0,0,0, 0,0,32'h0,        7,9,0,  1, 0,0,0,                               0,0,1,0);

        // Reset, then every address must read back as zero and idle
        @(negedge clk);
        v = vecs[0];
        drive(v);
        m_step();
        @(posedge clk);
        for (int a = 0; a < NR; a++) begin
            @(negedge clk);
            v = vecs[1];
            v.a1 = 5'(a); v.a2 = 5'(a); v.ad = 5'(a);
            drive(v);
            #2;
            chk("rst_rs1_data", bus.rs1_data, 32'h0);
            chk("rst_rs2_data", bus.rs2_data, 32'h0);
            chk("rst_dbg_data", bus.dbg_data, 32'h0);
            chk("rst_busy", {30'h0, bus.rs1_busy, bus.rs2_busy}, 32'h0);
            chk("rst_ready_err", {30'h0, bus.issue_ready, bus.wb_err}, 32'h2);
            m_step();
            @(posedge clk);
        end

        // Directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            drive(v);
            #2;
            if (v.chk) begin
                chk($sformatf("v%0d_rs1_data", i), bus.rs1_data, v.e1);
                chk($sformatf("v%0d_rs2_data", i), bus.rs2_data, v.e2);
                chk($sformatf("v%0d_dbg_data", i), bus.dbg_data, v.ed);
                chk($sformatf("v%0d_rs1_busy", i), {31'h0, bus.rs1_busy}, {31'h0, v.eb1});
                chk($sformatf("v%0d_rs2_busy", i), {31'h0, bus.rs2_busy}, {31'h0, v.eb2});
                chk($sformatf("v%0d_issue_ready", i), {31'h0, bus.issue_ready}, {31'h0, v.erdy});
                chk($sformatf("v%0d_wb_err", i), {31'h0, bus.wb_err}, {31'h0, v.eerr});
            end
            m_step();
            @(posedge clk);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int pend[$];
            @(negedge clk);
            pend.delete();
            for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) pend.push_back(r);
            v.rst = ($urandom_range(0, 299) == 0);
            v.iv  = ($urandom_range(0, 99) < 55);
            v.ird = 5'($urandom_range(0, 7));
            v.wv  = ($urandom_range(0, 99) < 45);
            if (pend.size() > 0 && $urandom_range(0, 99) < 80)
                v.wa = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                v.wa = 5'($urandom_range(0, 7));
            v.wd  = $urandom;
            v.a1  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.a2  = 5'($urandom_range(0, 7));
            v.ad  = 5'($urandom_range(0, 7));
            v.chk = 1'b1;
            drive(v);
            #2;
            if (!v.rst) check_model("rnd");
            m_step();
            @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
